gear_shift_scheduler: RTL and testbench

Automatic shift controller for the gearbox FSM.
- Integrates a vehicle-speed estimate from throttle and brake inputs, one update per slow tick.
- Decides upshifts and downshifts with hysteresis and a minimum dwell time between shifts.
- Drives the FSM's shift_up/shift_down inputs with single-clock pulses and tracks the commanded gear for display.
- Sits between the pushbutton/clock-divider layer and the gearbox FSM.

---
 rtl/gear_shift_scheduler.sv | 135 +++++++++++++
 tb/tb_gear_shift_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gear_shift_scheduler.sv
// Automatic gearbox shift controller: integrates a speed estimate on each slow tick and
// issues single-clock upshift/downshift pulses with hysteresis and a dwell between shifts.
module gear_shift_scheduler #(
    parameter int MAX_GEAR    = 5,
    parameter int SPEED_W     = 8,
    parameter int UP_STEP     = 40,
    parameter int DOWN_HYST   = 8,
    parameter int ACCEL       = 4,
    parameter int DECEL       = 1,
    parameter int BRAKE_DECEL = 8,
    parameter int DWELL       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               throttle,
    input  logic               brake,
    output logic               shift_up,
    output logic               shift_down,
    output logic [2:0]         gear,
    output logic [SPEED_W-1:0] speed,
    output logic               busy
);

    localparam int TW   = SPEED_W + 3;
    localparam int DW_W = (DWELL < 2) ? 1 : $clog2(DWELL + 1);

    typedef enum logic [1:0] {EVAL, UP, DOWN, DWELL_WAIT} state_t;

    state_t             state_reg;
    logic [SPEED_W-1:0] speed_reg, speed_next;
    logic [SPEED_W:0]   speed_sum;
    logic [2:0]         gear_reg, gear_dec;
    logic [DW_W-1:0]    dwell_reg;
    logic               shift_up_reg, shift_down_reg, busy_reg;

    logic [TW-1:0]      thresh [0:7];
    logic [TW-1:0]      speed_ext, speed_hyst;
    logic               up_ok, down_ok;

    // Per-gear upshift thresholds, wide enough that gear*UP_STEP cannot overflow
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_thresh
            assign thresh[gi] = TW'(gi * UP_STEP);
        end
    endgenerate

    always_comb begin
        gear_dec   = gear_reg - 3'd1;
        speed_ext  = TW'(speed_reg);
        speed_hyst = speed_ext + TW'(DOWN_HYST);
        up_ok      = (gear_reg < 3'(MAX_GEAR)) && (speed_ext >= thresh[gear_reg]);
        down_ok    = (gear_reg > 3'd1) && (speed_hyst < thresh[gear_dec]);
    end

    // Saturating speed integrator; brake has priority over throttle
    always_comb begin
        speed_sum  = {1'b0, speed_reg} + (SPEED_W+1)'(ACCEL);
        speed_next = speed_reg;
        if (brake) begin
            speed_next = (speed_reg > SPEED_W'(BRAKE_DECEL)) ? speed_reg - SPEED_W'(BRAKE_DECEL) : '0;
        end else if (throttle) begin
            speed_next = speed_sum[SPEED_W] ? '1 : speed_sum[SPEED_W-1:0];
        end else begin
            speed_next = (speed_reg > SPEED_W'(DECEL)) ? speed_reg - SPEED_W'(DECEL) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= EVAL;
            speed_reg      <= '0;
            gear_reg       <= 3'd1;
            dwell_reg      <= '0;
            shift_up_reg   <= 1'b0;
            shift_down_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            if (tick) begin
                speed_reg <= speed_next;
            end
            case (state_reg)
                EVAL: begin
                    if (tick) begin
                        if (up_ok) begin
                            state_reg    <= UP;
                            shift_up_reg <= 1'b1;
                            busy_reg     <= 1'b1;
                        end else if (down_ok) begin
                            state_reg      <= DOWN;
                            shift_down_reg <= 1'b1;
                            busy_reg       <= 1'b1;
                        end
                    end
                end
                UP: begin
                    shift_up_reg <= 1'b0;
                    gear_reg     <= gear_reg + 3'd1;
                    dwell_reg    <= DW_W'(DWELL);
                    state_reg    <= DWELL_WAIT;
                end
                DOWN: begin
                    shift_down_reg <= 1'b0;
                    gear_reg       <= gear_dec;
                    dwell_reg      <= DW_W'(DWELL);
                    state_reg      <= DWELL_WAIT;
                end
                DWELL_WAIT: begin
                    if (tick) begin
                        dwell_reg <= dwell_reg - DW_W'(1);
                        // A standstill above first gear skips the dwell so downshifts cascade
                        if ((dwell_reg == DW_W'(1)) || ((speed_reg == '0) && (gear_reg > 3'd1))) begin
                            state_reg <= EVAL;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg      <= EVAL;
                    shift_up_reg   <= 1'b0;
                    shift_down_reg <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign shift_up   = shift_up_reg;
    assign shift_down = shift_down_reg;
    assign gear       = gear_reg;
    assign speed      = speed_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_gear_shift_scheduler.sv
// Scoreboard bench for gear_shift_scheduler: a default instance plus a long-dwell instance
// used to exercise the standstill dwell cut-short.
module tb_gear_shift_scheduler;

    typedef struct packed {
        logic       up;
        logic [2:0] gear;
        logic [7:0] speed;
    } exp_t;

    logic clk = 1'b0;
    logic reset, reset2, tick, throttle, brake;
    logic shift_up1, shift_down1, busy1, shift_up2, shift_down2, busy2;
    logic [2:0] gear1, gear2;
    logic [7:0] speed1, speed2;

    exp_t q1[$];
    exp_t q2[$];
    int vectors = 0;
    int miscompares = 0;
    int up_cnt1 = 0;
    int dn_cnt1 = 0;

    always #5 clk = ~clk;

    gear_shift_scheduler u_dut (
        .clk(clk), .reset(reset), .tick(tick), .throttle(throttle), .brake(brake),
        .shift_up(shift_up1), .shift_down(shift_down1), .gear(gear1), .speed(speed1), .busy(busy1)
    );

    gear_shift_scheduler #(.DWELL(12)) u_dut_long (
        .clk(clk), .reset(reset2), .tick(tick), .throttle(throttle), .brake(brake),
        .shift_up(shift_up2), .shift_down(shift_down2), .gear(gear2), .speed(speed2), .busy(busy2)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_pulse(input string tag, input logic up, input logic dn, input logic [2:0] g,
                               input logic [7:0] s, input bit have, input exp_t e);
        check({tag, " exclusive"}, int'(up & dn), 0);
        if (!have) begin
            vectors++;
            miscompares++;
            $display("FAIL %s unexpected pulse: up=%0d down=%0d gear=%0d speed=%0d, expected none",
                     tag, up, dn, g, s);
        end else begin
            check({tag, " direction"}, int'(up), int'(e.up));
            check({tag, " gear"}, int'(g), int'(e.gear));
            check({tag, " speed"}, int'(s), int'(e.speed));
        end
    endtask

    function automatic exp_t mk(input logic up, input int g, input int s);
        exp_t e;
        e.up    = up;
        e.gear  = 3'(g);
        e.speed = 8'(s);
        return e;
    endfunction

    // Monitors: every pulse the DUT presents is matched against the next queued expectation
    always @(negedge clk) begin
        exp_t e;
        bit have;
        if (shift_up1 === 1'b1 || shift_down1 === 1'b1) begin
            if (shift_up1 === 1'b1) up_cnt1++;
            if (shift_down1 === 1'b1) dn_cnt1++;
            have = (q1.size() != 0);
            e = have ? q1.pop_front() : '0;
            check_pulse("dut pulse", shift_up1, shift_down1, gear1, speed1, have, e);
            $display("pulse dut: up=%0d down=%0d gear=%0d speed=%0d", shift_up1, shift_down1, gear1, speed1);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit have;
        if (shift_up2 === 1'b1 || shift_down2 === 1'b1) begin
            have = (q2.size() != 0);
            e = have ? q2.pop_front() : '0;
            check_pulse("long-dwell pulse", shift_up2, shift_down2, gear2, speed2, have, e);
            $display("pulse long-dwell: up=%0d down=%0d gear=%0d speed=%0d", shift_up2, shift_down2, gear2, speed2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with throttle and tick active
        reset = 1'b1; reset2 = 1'b1; tick = 1'b1; throttle = 1'b1; brake = 1'b0;
        step(); step();
        check("reset gear", int'(gear1), 1);
        check("reset speed", int'(speed1), 0);
        check("reset shift_up", int'(shift_up1), 0);
        check("reset shift_down", int'(shift_down1), 0);
        check("reset busy", int'(busy1), 0);
        check("reset long speed", int'(speed2), 0);

        // Full-throttle run to saturation
        q1.push_back(mk(1, 1, 44));  q1.push_back(mk(1, 2, 84));
        q1.push_back(mk(1, 3, 124)); q1.push_back(mk(1, 4, 164));
        q2.push_back(mk(1, 1, 44));  q2.push_back(mk(1, 2, 100));
        q2.push_back(mk(1, 3, 156)); q2.push_back(mk(1, 4, 212));
        reset = 1'b0; reset2 = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            step();
            case (n)
                10: begin check("t10 speed", int'(speed1), 40); check("t10 shift_up", int'(shift_up1), 0); end
                11: begin check("t11 shift_up", int'(shift_up1), 1); check("t11 busy", int'(busy1), 1); end
                12: begin check("t12 gear", int'(gear1), 2); check("t12 shift_up", int'(shift_up1), 0); end
                15: check("t15 busy in dwell", int'(busy1), 1);
                16: check("t16 busy after dwell", int'(busy1), 0);
                20: begin check("t20 gear", int'(gear1), 2); check("t20 speed", int'(speed1), 80); end
                63: check("t63 speed", int'(speed1), 252);
                64: check("t64 speed saturate", int'(speed1), 255);
                default: ;
            endcase
        end
        check("sat speed", int'(speed1), 255);
        check("sat gear", int'(gear1), 5);
        check("sat long gear", int'(gear2), 5);
        check("upshift count", up_cnt1, 4);
        check("downshift count", dn_cnt1, 0);

        // Hard stop from top gear
        q1.push_back(mk(0, 5, 143)); q1.push_back(mk(0, 4, 95));
        q1.push_back(mk(0, 3, 47));  q1.push_back(mk(0, 2, 0));
        q2.push_back(mk(0, 5, 143)); q2.push_back(mk(0, 4, 31));
        q2.push_back(mk(0, 3, 0));   q2.push_back(mk(0, 2, 0));
        throttle = 1'b0; brake = 1'b1;
        for (int b = 1; b <= 40; b++) begin
            step();
            case (b)
                32: check("stop speed floor", int'(speed1), 0);
                33: begin check("stop gear", int'(gear1), 1); check("long early exit busy", int'(busy2), 0); end
                37: check("long cascade shift_down", int'(shift_down2), 1);
                default: ;
            endcase
        end
        check("stop end gear", int'(gear1), 1);
        check("stop end long gear", int'(gear2), 1);
        check("stop end long speed", int'(speed2), 0);
        reset2 = 1'b1;

        // Brake overriding throttle from third gear
        brake = 1'b0; throttle = 1'b1; reset = 1'b1;
        step(); step();
        q1.push_back(mk(1, 1, 44)); q1.push_back(mk(1, 2, 84));
        q1.push_back(mk(0, 3, 60)); q1.push_back(mk(0, 2, 12));
        reset = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 30) brake = 1'b1;
            step();
            case (n)
                29: begin check("brk start gear", int'(gear1), 3); check("brk start speed", int'(speed1), 116); end
                35: begin check("brk hyst gear", int'(gear1), 3); check("brk hyst speed", int'(speed1), 68); end
                default: ;
            endcase
        end
        check("brk end gear", int'(gear1), 1);
        check("brk end speed", int'(speed1), 0);
        check("brk end busy", int'(busy1), 0);

        // Reset landing in the middle of an upshift
        brake = 1'b0; reset = 1'b1;
        step(); step();
        q1.push_back(mk(1, 1, 44)); q1.push_back(mk(1, 2, 84));
        reset = 1'b0;
        for (int n = 1; n <= 21; n++) step();
        check("midshift pending up", int'(shift_up1), 1);
        reset = 1'b1;
        step();
        check("midshift shift_up dropped", int'(shift_up1), 0);
        check("midshift gear", int'(gear1), 1);
        check("midshift speed", int'(speed1), 0);
        reset = 1'b0; throttle = 1'b0;
        for (int n = 1; n <= 20; n++) step();
        check("coast speed", int'(speed1), 0);
        check("coast gear", int'(gear1), 1);

        check("pending dut expectations", q1.size(), 0);
        check("pending long expectations", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
